// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward selects and
// the multi-cycle handshake FSM state type.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, holds at all-ones.
// Ports: clk, rst (async active-low), inc, count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;
  assign count  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: M/W forwarding, load-use stall,
// branch flush, multi-cycle unit handshake with watchdog,
// saturating stall/flush counters.
// Ports: clk, rst (async active-low); decode/execute
// register indices and write enables in; forward
// selects, stall/flush/bubble, mc_start/abort/err and
// the two counters out.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  resultsrc_e,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  pcsrc_e,
  input  logic                  mc_op_e,
  input  logic                  mc_done,
  output logic [1:0]            forward_ae,
  output logic [1:0]            forward_be,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  bubble_m,
  output logic                  mc_start,
  output logic                  mc_abort,
  output logic                  mc_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WD_W = $clog2(MC_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(MC_TIMEOUT - 1);

  mc_state_e       r_state;
  mc_state_e       w_state_nxt;
  logic [WD_W-1:0] r_wdog;
  logic [WD_W-1:0] w_wdog_nxt;
  logic            r_mc_err;

  logic            w_start;
  logic            w_mc_stall;
  logic            w_abort;
  logic            w_lu;
  logic            w_lu_stall;
  logic            w_nz_e;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] dm,
    input logic                  we_w,
    input logic [REG_ADDR_W-1:0] dw
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (we_m && dm != '0 && dm == rs) begin
      sel = FWD_MEM;
    end else if (we_w && dw != '0 && dw == rs) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Multi-cycle handshake: a zero-wait unit (done in the
  // start cycle) never stalls; otherwise hold until done
  // or until the watchdog runs out.
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_start     = 1'b0;
    w_mc_stall  = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (mc_op_e && !pcsrc_e) begin
          w_start = 1'b1;
          if (!mc_done) begin
            w_mc_stall  = 1'b1;
            w_wdog_nxt  = '0;
            w_state_nxt = MC_WAIT;
          end
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          w_state_nxt = RUN;
        end else if (r_wdog == WD_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_mc_stall = 1'b1;
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign w_nz_e = (rd_e != '0);
  assign w_lu   = resultsrc_e && w_nz_e &&
                  (rd_e == rs1_d || rd_e == rs2_d);

  // Branch wins over load-use; a frozen E (MC stall)
  // makes load-use meaningless so it is masked.
  assign w_lu_stall = w_lu && !pcsrc_e && !w_mc_stall;

  // Everything combinational is forced low in reset.
  always_comb begin
    forward_ae = FWD_REG;
    forward_be = FWD_REG;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    bubble_m   = 1'b0;
    mc_start   = 1'b0;
    mc_abort   = 1'b0;
    if (rst) begin
      forward_ae = fwd_sel(rs1_e, regwrite_m, rd_m,
                           regwrite_w, rd_w);
      forward_be = fwd_sel(rs2_e, regwrite_m, rd_m,
                           regwrite_w, rd_w);
      stall_f    = w_mc_stall || w_lu_stall;
      stall_d    = w_mc_stall || w_lu_stall;
      stall_e    = w_mc_stall;
      bubble_m   = w_mc_stall;
      flush_d    = pcsrc_e;
      flush_e    = pcsrc_e || w_lu_stall;
      mc_start   = w_start;
      mc_abort   = w_abort;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_wdog   <= '0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wdog   <= w_wdog_nxt;
      r_mc_err <= r_mc_err | w_abort;
    end
  end

  assign mc_err = r_mc_err;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_f),
    .count(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pcsrc_e),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random
// traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int TMO  = 8;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e;
  logic [AW-1:0] rd_e, rd_m, rd_w;
  logic          resultsrc_e, regwrite_m, regwrite_w;
  logic          pcsrc_e, mc_op_e, mc_done;
  logic [1:0]    forward_ae, forward_be;
  logic          stall_f, stall_d, stall_e;
  logic          flush_d, flush_e, bubble_m;
  logic          mc_start, mc_abort, mc_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: waiting flag, cycles since start
  bit m_wait;
  int m_n;
  bit m_err;
  int m_sc, m_fc;
  int e_fa, e_fb, e_sf, e_sd, e_se;
  int e_fd, e_fe, e_bm, e_st, e_ab;

  hazard_ctrl #(
    .REG_ADDR_W(AW),
    .CNT_W     (CW),
    .MC_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .resultsrc_e(resultsrc_e),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .pcsrc_e    (pcsrc_e),
    .mc_op_e    (mc_op_e),
    .mc_done    (mc_done),
    .forward_ae (forward_ae),
    .forward_be (forward_be),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .bubble_m   (bubble_m),
    .mc_start   (mc_start),
    .mc_abort   (mc_abort),
    .mc_err     (mc_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic int fsel(input int rs);
    if (regwrite_m && rd_m != 0 && int'(rd_m) == rs)
      return 2;
    if (regwrite_w && rd_w != 0 && int'(rd_w) == rs)
      return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_wait = 0;
    m_n    = 0;
    m_err  = 0;
    m_sc   = 0;
    m_fc   = 0;
  endfunction

  function automatic void model_comb();
    int mcst, lu, lue;
    {e_fa, e_fb, e_sf, e_sd, e_se} = '0;
    {e_fd, e_fe, e_bm, e_st, e_ab} = '0;
    if (rst) begin
      e_fa = fsel(int'(rs1_e));
      e_fb = fsel(int'(rs2_e));
      mcst = 0;
      if (!m_wait) begin
        e_st = (mc_op_e && !pcsrc_e) ? 1 : 0;
        mcst = (e_st == 1 && !mc_done) ? 1 : 0;
      end else begin
        e_ab = (!mc_done && m_n == TMO) ? 1 : 0;
        mcst = (!mc_done && e_ab == 0) ? 1 : 0;
      end
      lu = (resultsrc_e && rd_e != 0 &&
            (rd_e == rs1_d || rd_e == rs2_d)) ? 1 : 0;
      lue = (lu == 1 && !pcsrc_e && mcst == 0) ? 1 : 0;
      e_sf = mcst | lue;
      e_sd = mcst | lue;
      e_se = mcst;
      e_bm = mcst;
      e_fd = int'(pcsrc_e);
      e_fe = int'(pcsrc_e) | lue;
    end
  endfunction

  function automatic void model_seq();
    if (e_sf != 0 && m_sc < SMAX) m_sc++;
    if (pcsrc_e && m_fc < SMAX) m_fc++;
    if (e_ab != 0) m_err = 1;
    if (!m_wait) begin
      if (e_se != 0) begin
        m_wait = 1;
        m_n    = 1;
      end
    end else if (mc_done || e_ab != 0) begin
      m_wait = 0;
    end else begin
      m_n++;
    end
  endfunction

  task automatic check_comb(input string p);
    chk({p, ".fa"}, 32'(forward_ae), 32'(e_fa));
    chk({p, ".fb"}, 32'(forward_be), 32'(e_fb));
    chk({p, ".sf"}, 32'(stall_f), 32'(e_sf));
    chk({p, ".sd"}, 32'(stall_d), 32'(e_sd));
    chk({p, ".se"}, 32'(stall_e), 32'(e_se));
    chk({p, ".fd"}, 32'(flush_d), 32'(e_fd));
    chk({p, ".fe"}, 32'(flush_e), 32'(e_fe));
    chk({p, ".bm"}, 32'(bubble_m), 32'(e_bm));
    chk({p, ".start"}, 32'(mc_start), 32'(e_st));
    chk({p, ".abort"}, 32'(mc_abort), 32'(e_ab));
  endtask

  task automatic check_regs(input string p);
    chk({p, ".scnt"}, 32'(stall_cnt), 32'(m_sc));
    chk({p, ".fcnt"}, 32'(flush_cnt), 32'(m_fc));
    chk({p, ".err"}, 32'(mc_err), 32'(m_err));
  endtask

  // called at posedge+1; inputs already applied
  task automatic tick(input string p);
    #2;
    model_comb();
    check_comb(p);
    @(posedge clk);
    model_seq();
    #1;
    check_regs(p);
  endtask

  task automatic clr_in();
    {rs1_d, rs2_d, rs1_e, rs2_e} = '0;
    {rd_e, rd_m, rd_w} = '0;
    {resultsrc_e, regwrite_m, regwrite_w} = '0;
    {pcsrc_e, mc_op_e, mc_done} = '0;
  endtask

  task automatic do_reset(input string p);
    rst = 1'b0;
    model_reset();
    #2;
    model_comb();
    check_comb(p);
    check_regs(p);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    clr_in();
    // outputs forced low in reset even with live inputs
    pcsrc_e     = 1'b1;
    mc_op_e     = 1'b1;
    regwrite_m  = 1'b1;
    rd_m        = 5'd3;
    rs1_e       = 5'd3;
    resultsrc_e = 1'b1;
    rd_e        = 5'd2;
    rs1_d       = 5'd2;
    #3;
    model_comb();
    check_comb("rst");
    check_regs("rst");
    chk("rst.fa0", 32'(forward_ae), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_in();

    // forwarding M over W, then W, then x0
    rd_m = 5'd5; rd_w = 5'd5;
    regwrite_m = 1'b1; regwrite_w = 1'b1;
    rs1_e = 5'd5;
    #1 chk("fwd.mem", 32'(forward_ae), 32'd2);
    tick("fwd_m");
    regwrite_m = 1'b0;
    #1 chk("fwd.wb", 32'(forward_ae), 32'd1);
    tick("fwd_w");
    rd_m = 5'd0; rs1_e = 5'd0; regwrite_m = 1'b1;
    rd_w = 5'd0;
    tick("fwd_0");
    clr_in();

    // load-use, one cycle
    do_reset("r1");
    resultsrc_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    tick("lu");
    clr_in();
    tick("lu_after");
    chk("lu.scnt1", 32'(stall_cnt), 32'd1);

    // branch beats load-use
    resultsrc_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    pcsrc_e = 1'b1;
    tick("br");
    chk("br.fcnt1", 32'(flush_cnt), 32'd1);
    clr_in();

    // handshake with done 4 cycles after start
    do_reset("r2");
    mc_op_e = 1'b1;
    for (int c = 0; c < 4; c++) tick("hs_w");
    mc_done = 1'b1;
    tick("hs_d");
    clr_in();
    tick("hs_run");
    chk("hs.scnt4", 32'(stall_cnt), 32'd4);

    // zero-wait unit
    mc_op_e = 1'b1; mc_done = 1'b1;
    tick("zw");
    clr_in();
    tick("zw_run");

    // watchdog expiry
    do_reset("r3");
    mc_op_e = 1'b1;
    for (int c = 0; c < TMO; c++) tick("wd_w");
    #2 chk("wd.abort", 32'(mc_abort), 32'd1);
    tick("wd_a");
    clr_in();
    for (int c = 0; c < 3; c++) tick("wd_sticky");
    chk("wd.err", 32'(mc_err), 32'd1);

    // async reset mid-wait
    mc_op_e = 1'b1;
    tick("ar_s");
    tick("ar_w");
    do_reset("ar");
    clr_in();
    tick("ar_run");

    // saturation
    resultsrc_e = 1'b1; rd_e = 5'd4; rs2_d = 5'd4;
    for (int c = 0; c < 10; c++) tick("sat");
    chk("sat.scnt", 32'(stall_cnt), 32'(SMAX));
    clr_in();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) do_reset("rr");
      rs1_d = AW'($urandom_range(0, 3));
      rs2_d = AW'($urandom_range(0, 3));
      rs1_e = AW'($urandom_range(0, 3));
      rs2_e = AW'($urandom_range(0, 3));
      rd_e  = AW'($urandom_range(0, 3));
      rd_m  = AW'($urandom_range(0, 3));
      rd_w  = AW'($urandom_range(0, 3));
      resultsrc_e = ($urandom_range(0, 2) == 0);
      regwrite_m  = $urandom_range(0, 1) != 0;
      regwrite_w  = $urandom_range(0, 1) != 0;
      pcsrc_e     = ($urandom_range(0, 7) == 0);
      mc_op_e     = ($urandom_range(0, 3) == 0);
      mc_done     = ($urandom_range(0, 9) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
